// File: rtl/fb_scanout.sv
// fb_scanout
// ----------
// Framebuffer scan-out timing generator. Raster-scans a framebuffer RAM with a
// configurable H/V timing, produces the pixel enable, syncs and blanks, and
// locks each raster restart to the producer's frame-complete pulse.
//
// Build option:
//   FB_SCANOUT_DOUBLE_BUF_EN  defined   -> two pages, page flip at each locked restart
//                             undefined -> single page, page_wr tied to 0
//
// Ports:
//   clk_sys     system clock
//   reset_n     asynchronous active-low reset
//   lock_en     1: frame restart waits for a pending frame, 0: free-run
//   frame_done  one-cycle pulse, producer finished writing a frame
//   page_wr     page the producer must write
//   rd_addr     framebuffer read address (page base + linear pixel index)
//   rd_data     RAM read data, valid one cycle after rd_addr
//   ce_pix      one-cycle pixel enable
//   rgb         pixel data, valid while ce_pix is high
//   hs, vs      active-high syncs
//   hbl, vbl    active-high blanks
//   drop_cnt    saturating count of frames overwritten before display
module fb_scanout #(
    parameter int H_ACTIVE = 240,
    parameter int H_TOTAL  = 256,
    parameter int HS_START = 244,
    parameter int HS_END   = 252,
    parameter int V_ACTIVE = 160,
    parameter int V_TOTAL  = 256,
    parameter int VS_START = 163,
    parameter int VS_END   = 166,
    parameter int CE_DIV   = 4,
    parameter int PIX_W    = 15,
    parameter int ADDR_W   = 17
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              lock_en,
    input  logic              frame_done,
    output logic              page_wr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              ce_pix,
    output logic [PIX_W-1:0]  rgb,
    output logic              hs,
    output logic              vs,
    output logic              hbl,
    output logic              vbl,
    output logic [7:0]        drop_cnt
);

    localparam int XW = $clog2(H_TOTAL);
    localparam int YW = $clog2(V_TOTAL);
    localparam int DW = $clog2(CE_DIV);

    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

    logic [DW-1:0]     div_q, div_d;
    logic [XW-1:0]     x_q, x_d;
    logic [YW-1:0]     y_q, y_d;
    logic [ADDR_W-1:0] lin_q, lin_d;
    logic              pending_q, pending_d;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic              ce_pix_q, ce_pix_d;
    logic [PIX_W-1:0]  rgb_q, rgb_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              hbl_q, hbl_d;
    logic              vbl_q, vbl_d;
    logic              x_vis, y_vis, y_in_vs, restart;

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
    // Page 1 starts one full page above page 0; a mux of two constants, no multiplier.
    localparam logic [ADDR_W-1:0] PAGE_SIZE = ADDR_W'(H_ACTIVE * V_ACTIVE);

    logic page_rd_q, page_rd_d;
    logic page_wr_q, page_wr_d;
    logic flip;

    assign rd_addr = (page_rd_q ? PAGE_SIZE : '0) + lin_q;
    assign page_wr = page_wr_q;
`else
    assign rd_addr = lin_q;
    assign page_wr = 1'b0;
`endif

    assign ce_pix   = ce_pix_q;
    assign rgb      = rgb_q;
    assign hs       = hs_q;
    assign vs       = vs_q;
    assign hbl      = hbl_q;
    assign vbl      = vbl_q;
    assign drop_cnt = drop_cnt_q;

    always_comb begin
        div_d      = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        x_d        = x_q;
        y_d        = y_q;
        lin_d      = lin_q;
        ce_pix_d   = 1'b0;
        rgb_d      = rgb_q;
        hs_d       = hs_q;
        vs_d       = vs_q;
        hbl_d      = hbl_q;
        vbl_d      = vbl_q;
        drop_cnt_d = drop_cnt_q;
        restart    = 1'b0;

        x_vis   = int'(x_q) < H_ACTIVE;
        y_vis   = int'(y_q) < V_ACTIVE;
        y_in_vs = (int'(y_q) >= VS_START) && (int'(y_q) < VS_END);

        // Output stage: rd_data already reflects the address that has been
        // stable since the previous ce_pix, so it belongs to pixel (x_q, y_q).
        if (div_q == '0) begin
            ce_pix_d = 1'b1;
            rgb_d    = rd_data;
            hbl_d    = !x_vis;
            vbl_d    = !y_vis;
            hs_d     = (int'(x_q) >= HS_START) && (int'(x_q) < HS_END);
            // vs only changes at the start of hsync so it is line-aligned to hs.
            if (int'(x_q) == HS_START) begin
                vs_d = y_in_vs;
            end
        end

        // Raster advance. At the last line the scan either restarts or holds
        // on the blanked last line until the producer has a frame ready.
        if (ce_pix_q) begin
            if (x_vis && y_vis) begin
                lin_d = lin_q + 1'b1;
            end
            if (x_q != X_LAST) begin
                x_d = x_q + 1'b1;
            end else begin
                x_d = '0;
                if (y_q != Y_LAST) begin
                    y_d = y_q + 1'b1;
                end else if (pending_q || !lock_en) begin
                    restart = 1'b1;
                    y_d     = '0;
                    lin_d   = '0;
                end
            end
        end

        // A frame_done on the restart cycle re-arms pending (set beats clear).
        pending_d = restart ? 1'b0 : pending_q;
        if (frame_done) begin
            pending_d = 1'b1;
            if (pending_q && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
        // The new page is shown from pixel (0,0) because lin and page change together.
        flip      = restart && pending_q;
        page_rd_d = page_rd_q;
        page_wr_d = page_wr_q;
        if (flip) begin
            page_rd_d = page_wr_q;
            page_wr_d = !page_wr_q;
        end
`endif
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            lin_q      <= '0;
            pending_q  <= 1'b0;
            drop_cnt_q <= 8'd0;
            ce_pix_q   <= 1'b0;
            rgb_q      <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hbl_q      <= 1'b0;
            vbl_q      <= 1'b0;
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
            page_rd_q  <= 1'b0;
            page_wr_q  <= 1'b1;
`endif
        end else begin
            div_q      <= div_d;
            x_q        <= x_d;
            y_q        <= y_d;
            lin_q      <= lin_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
            ce_pix_q   <= ce_pix_d;
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            hbl_q      <= hbl_d;
            vbl_q      <= vbl_d;
`ifdef FB_SCANOUT_DOUBLE_BUF_EN
            page_rd_q  <= page_rd_d;
            page_wr_q  <= page_wr_d;
`endif
        end
    end

endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout
// -------------
// Bench for fb_scanout using a reduced raster (12x7 pixels, 8x4 visible) so
// several whole frames fit in a short run. A behavioural RAM returns a tag
// derived from the read address, so every displayed pixel identifies the
// address it came from. Each scenario task pushes the expected pixel stream
// into a queue and pops one entry per ce_pix.
module tb_fb_scanout;

    localparam int HA    = 8;
    localparam int HT    = 12;
    localparam int HSS   = 9;
    localparam int HSE   = 11;
    localparam int VA    = 4;
    localparam int VT    = 7;
    localparam int VSS   = 4;
    localparam int VSE   = 6;
    localparam int CE    = 4;
    localparam int PW    = 15;
    localparam int AW    = 8;
    localparam int FRAME = HT * VT;

`ifdef FB_SCANOUT_DOUBLE_BUF_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    typedef struct packed {
        logic          hbl;
        logic          vbl;
        logic          hs;
        logic          vs;
        logic          page_wr;
        logic [AW-1:0] addr;
        logic [PW-1:0] rgb;
    } pix_t;

    logic          clk_sys;
    logic          reset_n;
    logic          lock_en;
    logic          frame_done;
    logic          page_wr;
    logic [AW-1:0] rd_addr;
    logic [PW-1:0] rd_data;
    logic          ce_pix;
    logic [PW-1:0] rgb;
    logic          hs, vs, hbl, vbl;
    logic [7:0]    drop_cnt;

    pix_t sb[$];
    int   checks = 0;
    int   errors = 0;

    fb_scanout #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HSS), .HS_END(HSE),
        .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VSS), .VS_END(VSE),
        .CE_DIV(CE), .PIX_W(PW), .ADDR_W(AW)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .lock_en(lock_en),
        .frame_done(frame_done), .page_wr(page_wr), .rd_addr(rd_addr),
        .rd_data(rd_data), .ce_pix(ce_pix), .rgb(rgb), .hs(hs), .vs(vs),
        .hbl(hbl), .vbl(vbl), .drop_cnt(drop_cnt)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // One-cycle-latency RAM whose content is a tag of its address.
    always @(posedge clk_sys) rd_data <= {7'h55, rd_addr};

    // Expected pixels of one line; prev_y is the line whose vs state is
    // still shown before hsync starts.
    task automatic push_line(input int y, input int prev_y, input int flips);
        pix_t p;
        int   lin;
        int   vy;
        for (int x = 0; x < HT; x++) begin
            vy        = (x >= HSS) ? y : prev_y;
            lin       = (y < VA) ? (y * HA + ((x < HA) ? x : HA)) : (HA * VA);
            p.hbl     = (x >= HA);
            p.vbl     = (y >= VA);
            p.hs      = (x >= HSS) && (x < HSE);
            p.vs      = (vy >= VSS) && (vy < VSE);
            p.page_wr = DBL & ~flips[0];
            p.addr    = AW'(((DBL && flips[0]) ? HA * VA : 0) + lin);
            p.rgb     = {7'h55, p.addr};
            sb.push_back(p);
        end
    endtask

    task automatic push_frame(input int flips);
        for (int y = 0; y < VT; y++) begin
            push_line(y, (y == 0) ? VT - 1 : y - 1, flips);
        end
    endtask

    // Waits (bounded) for the next ce_pix; also ends any frame_done pulse.
    task automatic wait_ce(output int waited, output bit ok);
        waited = 0;
        ok     = 1'b0;
        for (int i = 0; i < 4 * CE; i++) begin
            @(negedge clk_sys);
            frame_done = 1'b0;
            waited++;
            if (ce_pix === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset(input bit lock);
        frame_done = 1'b0;
        lock_en    = lock;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk_sys);
        sb.delete();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        frame_done = 1'b0;
        lock_en    = 1'b0;
        reset_n    = 1'b0;
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({ce_pix, hs, vs, hbl, vbl} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got ce/hs/vs/hbl/vbl=%b, required 00000", {ce_pix, hs, vs, hbl, vbl});
        end
        checks++;
        if ({rgb, rd_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got rgb=%h rd_addr=%h, required 0 0", rgb, rd_addr);
        end
        checks++;
        if ({drop_cnt, page_wr} !== {8'd0, DBL}) begin
            errors++;
            $display("[TB] FAIL reset_cnt: got drop_cnt=%0d page_wr=%b, required 0 %b", drop_cnt, page_wr, DBL);
        end
    endtask

    task automatic test_free_run;
        int waited; bit ok; pix_t exp_p, got_p;
        apply_reset(1'b0);
        push_frame(0);
        push_frame(0);
        for (int i = 0; i < 2 * FRAME; i++) begin
            wait_ce(waited, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL free_run timeout at pixel %0d: got no ce_pix, required one", i);
                break;
            end
            checks++;
            if ((i == 0) ? (waited > 2) : (waited != CE)) begin
                errors++;
                $display("[TB] FAIL free_run ce_period at pixel %0d: got %0d cycles, required %0d", i, waited, (i == 0) ? 2 : CE);
            end
            exp_p = sb.pop_front();
            got_p = {hbl, vbl, hs, vs, page_wr, rd_addr, rgb};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("[TB] FAIL free_run pixel %0d: got %h, required %h", i, got_p, exp_p);
            end
        end
    endtask

    task automatic test_lock_stall;
        int waited; bit ok; pix_t exp_p, got_p;
        apply_reset(1'b1);
        push_frame(0);
        repeat (3) push_line(VT - 1, VT - 1, 0);
        push_frame(1);
        for (int i = 0; i < 2 * FRAME + 3 * HT; i++) begin
            wait_ce(waited, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL lock_stall timeout at pixel %0d: got no ce_pix, required one", i);
                break;
            end
            if (i == FRAME + 2 * HT + 3) frame_done = 1'b1;
            exp_p = sb.pop_front();
            got_p = {hbl, vbl, hs, vs, page_wr, rd_addr, rgb};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("[TB] FAIL lock_stall pixel %0d: got %h, required %h", i, got_p, exp_p);
            end
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL lock_stall drop_cnt: got %0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_double_flip;
        int waited; bit ok; pix_t exp_p, got_p;
        apply_reset(1'b1);
        for (int f = 0; f < 4; f++) push_frame(f);
        for (int i = 0; i < 4 * FRAME; i++) begin
            wait_ce(waited, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL double_flip timeout at pixel %0d: got no ce_pix, required one", i);
                break;
            end
            if ((i % FRAME == 10) && (i < 3 * FRAME)) frame_done = 1'b1;
            exp_p = sb.pop_front();
            got_p = {hbl, vbl, hs, vs, page_wr, rd_addr, rgb};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("[TB] FAIL double_flip pixel %0d: got %h, required %h", i, got_p, exp_p);
            end
        end
        checks++;
        if (drop_cnt !== 8'd0) begin
            errors++;
            $display("[TB] FAIL double_flip drop_cnt: got %0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_drops;
        int waited; bit ok; pix_t exp_p, got_p;
        apply_reset(1'b1);
        push_frame(0);
        push_frame(1);
        for (int i = 0; i < 2 * FRAME; i++) begin
            wait_ce(waited, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL drops timeout at pixel %0d: got no ce_pix, required one", i);
                break;
            end
            if (i == 5 || i == 20 || i == 40) frame_done = 1'b1;
            exp_p = sb.pop_front();
            got_p = {hbl, vbl, hs, vs, page_wr, rd_addr, rgb};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("[TB] FAIL drops pixel %0d: got %h, required %h", i, got_p, exp_p);
            end
        end
        checks++;
        if (drop_cnt !== 8'd2) begin
            errors++;
            $display("[TB] FAIL drops count: got %0d, required 2", drop_cnt);
        end
        repeat (300) begin
            @(negedge clk_sys);
            frame_done = 1'b1;
        end
        @(negedge clk_sys);
        frame_done = 1'b0;
        @(negedge clk_sys);
        checks++;
        if (drop_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL drops saturate: got %0d, required 255", drop_cnt);
        end
    endtask

    task automatic test_coincident;
        int waited; bit ok; pix_t exp_p, got_p;
        apply_reset(1'b1);
        push_frame(0);
        push_frame(1);
        push_frame(2);
        for (int i = 0; i < 3 * FRAME; i++) begin
            wait_ce(waited, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL coincident timeout at pixel %0d: got no ce_pix, required one", i);
                break;
            end
            // The pulse after the last pixel of frame 0 lands on the restart edge.
            if (i == 10 || i == FRAME - 1) frame_done = 1'b1;
            exp_p = sb.pop_front();
            got_p = {hbl, vbl, hs, vs, page_wr, rd_addr, rgb};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("[TB] FAIL coincident pixel %0d: got %h, required %h", i, got_p, exp_p);
            end
        end
    endtask

    task automatic test_reset_mid;
        int waited; bit ok; pix_t exp_p, got_p;
        apply_reset(1'b0);
        push_frame(0);
        push_frame(1);
        // Stop on pixel (9,2) of the flipped frame, where hs and hbl are high.
        for (int i = 0; i < 2 * FRAME + 3 * FRAME; i++) begin
            if (i == FRAME + 2 * HT + 10) break;
            wait_ce(waited, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL reset_mid timeout at pixel %0d: got no ce_pix, required one", i);
                break;
            end
            if (i == 5 || i == 20) frame_done = 1'b1;
            exp_p = sb.pop_front();
            got_p = {hbl, vbl, hs, vs, page_wr, rd_addr, rgb};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("[TB] FAIL reset_mid pixel %0d: got %h, required %h", i, got_p, exp_p);
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({ce_pix, hs, vs, hbl, vbl} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid ctrl: got ce/hs/vs/hbl/vbl=%b, required 00000", {ce_pix, hs, vs, hbl, vbl});
        end
        checks++;
        if ({rgb, rd_addr} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_mid data: got rgb=%h rd_addr=%h, required 0 0", rgb, rd_addr);
        end
        checks++;
        if ({drop_cnt, page_wr} !== {8'd0, DBL}) begin
            errors++;
            $display("[TB] FAIL reset_mid cnt: got drop_cnt=%0d page_wr=%b, required 0 %b", drop_cnt, page_wr, DBL);
        end
        repeat (2) @(negedge clk_sys);
        sb.delete();
        reset_n = 1'b1;
        push_frame(0);
        for (int i = 0; i < FRAME; i++) begin
            wait_ce(waited, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL reset_mid restart timeout at pixel %0d: got no ce_pix, required one", i);
                break;
            end
            exp_p = sb.pop_front();
            got_p = {hbl, vbl, hs, vs, page_wr, rd_addr, rgb};
            checks++;
            if (got_p !== exp_p) begin
                errors++;
                $display("[TB] FAIL reset_mid restart pixel %0d: got %h, required %h", i, got_p, exp_p);
            end
        end
    endtask

    initial begin
        $display("[TB] fb_scanout bench, double buffer = %0d", DBL);
        test_reset();
        test_free_run();
        test_lock_stall();
        test_double_flip();
        test_drops();
        test_coincident();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of run by 1 ms, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fb_scanout.md
# fb_scanout

Parametrised framebuffer scan-out timing generator for MiSTer cores. It sits between the core's pixel-writing framebuffer RAM and `video_mixer`. It raster-scans the framebuffer in a configurable H/V timing and produces the pixel enable, syncs and blanks. Each restart of the raster is locked to the producer's frame-complete pulse, with optional double-buffered page flipping.

## Interface
Parameters:
- `H_ACTIVE`, 240: visible pixels per line.
- `H_TOTAL`, 256: pixel clocks per line, > `H_ACTIVE`.
- `HS_START` / `HS_END`, 244 / 252: hs asserted for x in [HS_START, HS_END).
- `V_ACTIVE`, 160: visible lines.
- `V_TOTAL`, 256: lines per frame, > `V_ACTIVE`.
- `VS_START` / `VS_END`, 163 / 166: vs asserted for lines in [VS_START, VS_END), changing at x == HS_START.
- `CE_DIV`, 4: clk_sys cycles per pixel, ≥ 2.
- `PIX_W`, 15: pixel width.
- `ADDR_W`, 17: framebuffer address width; must hold 2·H_ACTIVE·V_ACTIVE − 1.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous active-low reset.
- `lock_en`, in, 1: 1 = frame restart waits for a pending frame; 0 = free-run.
- `frame_done`, in, 1: one-cycle pulse when the producer has written the last pixel of a frame.
- `page_wr`, out, 1: page the producer must write.
- `rd_addr`, out, ADDR_W: framebuffer read address.
- `rd_data`, in, PIX_W: RAM output, valid 1 cycle after `rd_addr`.
- `ce_pix`, out, 1: one-cycle pixel enable.
- `rgb`, out, PIX_W: pixel, valid while `ce_pix` is high.
- `hs`, `vs`, `hbl`, `vbl`, out, 1 each: active-high sync and blank signals.
- `drop_cnt`, out, 8: saturating count of frames overwritten before being displayed.

## Operation
- Divider `div` counts 0..CE_DIV−1 and wraps. On a clock where div == 0, the next clock drives `ce_pix` = 1 and registers `rgb` ← `rd_data`, `hbl` ← (x ≥ H_ACTIVE), `vbl` ← (y ≥ V_ACTIVE), and the hs/vs compare results.
- Counters x, y advance on `ce_pix`:
  - If x < H_TOTAL−1, x increments.
  - Otherwise x ← 0. Then, if y < V_TOTAL−1, y increments.
  - Otherwise (end of frame), restart if `pending` or `lock_en` = 0: y ← 0, line address ← 0, flip. If neither holds, y stays at V_TOTAL−1; these stall lines extend vblank and repeat the blanked line.
- `rd_addr` = page_base + lin. lin increments on `ce_pix` when x < H_ACTIVE and y < V_ACTIVE. lin resets to 0 on restart.
- `pending` is set by `frame_done` and cleared on restart.
  - `frame_done` arriving while `pending` = 1 increments `drop_cnt`; it saturates at 255.
  - `frame_done` coinciding with a restart sets `pending` again, i.e. set wins over clear.
- Flip (double buffer only): page_rd ← page_wr and page_wr ← ~page_wr. This occurs only when `pending` is set at the restart.
- page_base = page_rd · H_ACTIVE·V_ACTIVE, computed at elaboration as a constant product, with no multiplier.

## Timing
- Reset values: div, x, y, lin, `pending`, `drop_cnt`, `ce_pix`, `hs`, `vs`, `hbl`, `vbl`, `rgb` = 0; page_rd = 0; `page_wr` = 1 with double buffering, 0 without.
- `rd_addr` leads `ce_pix` by CE_DIV−1 cycles, which is ≥ 1 and therefore meets the RAM's 1-cycle latency.
- Assertion of `reset_n` mid-frame aborts immediately. After release, the first `ce_pix` occurs 2 cycles later.
- `frame_done` is sampled every clk_sys cycle, independent of `ce_pix`.
- The flip takes effect exactly at the x = 0, y = 0 pixel, so no tearing occurs within a displayed frame.

## Configuration
- `FB_SCANOUT_DOUBLE_BUF_EN` defined:
  - two pages; `page_wr` toggles on each flip;
  - the producer writes the off-screen page while the displayed page stays untouched.
- `FB_SCANOUT_DOUBLE_BUF_EN` undefined:
  - single page; `page_wr` is tied to 0 and page_base to 0;
  - `pending`, `lock_en` and `drop_cnt` behave as above; this is the legacy hold-until-frame-written behaviour.

## Test plan
- Default params, `lock_en` = 0, no `frame_done`: `ce_pix` every 4th cycle. `hbl` high for x = 240..255. `hs` high for x = 244..251. `vs` high for lines 163..165. The frame repeats every 256·256·4 = 262144 cycles.
- `lock_en` = 1, no `frame_done`: y holds at 255 and `vbl` stays 1. Pulsing `frame_done` restarts at the next line end, and `rd_addr` goes to page_base + 0.
- Double buffer, `frame_done` pulsed once per frame: `page_wr` toggles 1→0→1 at each restart. `rd_addr` of the first pixel alternates 38400, 0, 38400. `drop_cnt` = 0.
- Three `frame_done` pulses within one displayed frame: `drop_cnt` = 2, and exactly one flip occurs at the restart. 300 excess pulses give `drop_cnt` saturated at 255.
- `frame_done` on the same cycle as a restart: flip occurs and `pending` = 1 afterwards, so the next frame restarts without stalling.
- Assert `reset_n` = 0 at y = 80: all outputs return to their reset values within the same cycle. After release, scan starts at x = 0, y = 0 and `rd_addr` = 0.
